// File: rtl/div_pkg.sv
// Shared constants for the iterative restoring divider: default widths, FSM encoding, step count.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int last_step(input int width);
        return width - 1;
    endfunction

    localparam int LAST_STEP = last_step(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract, keep or restore.
// Latency 0; no flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           trial_neg;

    // The shifted remainder can need WIDTH+1 bits when the divisor has its MSB set.
    assign shifted   = {rem_i, quo_i[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor_i};
    assign trial_neg = trial[WIDTH];

    assign rem_o = trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/div_multicycle.sv
// Iterative divider, one quotient bit per clock; ready 33 cycles after accept (1 for divide-by-zero).
// Start strobes during BUSY are dropped; define DIV_SIGNED_EN for two's-complement operands.
module div_multicycle
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(last_step(WIDTH));

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remain_q, remain_d;
    logic             exc_q, exc_d;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept, div_zero, last_w;

    assign accept   = ctrl_div && (state_q != BUSY);
    assign div_zero = (data_operandB == '0);
    assign last_w   = (state_q == BUSY) && (cnt_q == LAST_CNT);

`ifdef DIV_SIGNED_EN
    logic q_neg_q, r_neg_q, ovf_q;

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock) begin
        if (reset) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            q_neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_neg_q <= data_operandA[WIDTH-1];
            ovf_q   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        end
    end

    // Sign fix-up happens on the way into the output registers, so it costs no cycle.
    always_comb begin
        result_d = q_neg_q ? -step_quo : step_quo;
        remain_d = r_neg_q ? -step_rem : step_rem;
        exc_d    = ovf_q;
    end
`else
    assign a_mag = data_operandA;
    assign b_mag = data_operandB;

    always_comb begin
        result_d = step_quo;
        remain_d = step_rem;
        exc_d    = 1'b0;
    end
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = div_zero ? DONE : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (last_w) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q == BUSY);
        data_resultRDY = (state_q == DONE);
    end

    // Working registers stay apart from the output registers so results hold during the next op.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            remain_q <= '0;
            exc_q    <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= a_mag;
            dvs_q <= b_mag;
            if (div_zero) begin
                result_q <= '0;
                remain_q <= data_operandA;
                exc_q    <= 1'b1;
            end
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= step_rem;
            quo_q <= step_quo;
            if (last_w) begin
                result_q <= result_d;
                remain_q <= remain_d;
                exc_q    <= exc_d;
            end
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remain_q;
    assign data_exception = exc_q;

endmodule

// File: doc/div_multicycle.md
Name: div_multicycle

Overview:
- 32-bit iterative restoring divider for the processor's execute stage; a companion to the single-cycle bitwise and adder ALU paths.
- Takes a one-cycle start pulse with dividend and divisor, produces one quotient bit per clock, and returns quotient, remainder and a ready pulse.
- The pipeline stalls on the busy output until ready is seen.

Parameters:
- WIDTH, 32, operand/result width in bits (only 32 is verified)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high
- ctrl_div  input  1  start strobe, sampled each rising edge
- data_operandA  input  WIDTH  dividend, sampled only when ctrl_div is accepted
- data_operandB  input  WIDTH  divisor, sampled only when ctrl_div is accepted
- data_result  output  WIDTH  quotient
- data_remainder  output  WIDTH  remainder
- data_exception  output  1  divide-by-zero (and signed overflow when the optional feature is enabled); valid with data_resultRDY
- data_resultRDY  output  1  one-cycle pulse: results valid
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset value of every output and register is 0; the FSM resets to IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ctrl_div=1 latches operands, clears the partial remainder, sets count=0 and moves to BUSY. busy goes high the next cycle.
  - BUSY: one restoring step per cycle.
    - Shift {rem,quo} left by 1.
    - Compute trial = rem - divisor as a WIDTH+1 bit subtraction.
    - If trial is non-negative, rem=trial and quo[0]=1; otherwise quo[0]=0.
    - count increments; after step WIDTH-1 (32 steps) go to DONE.
  - DONE: data_resultRDY=1 for exactly this cycle; busy=0; return to IDLE.
- Latency: data_resultRDY is high in the 33rd cycle after the edge that accepted ctrl_div (accept edge = cycle 0, steps on cycles 1..32, DONE state visible in cycle 33).
- Divisor 0:
  - Detected at accept; skip BUSY and go directly to DONE.
  - data_result=0, data_remainder=dividend, data_exception=1.
  - Ready arrives in cycle 1.
- data_exception is 0 for every normal completion.
- data_result, data_remainder and data_exception hold their last values until the next accept. They do not change during BUSY, because internal working registers are separate from the output registers.
- ctrl_div while in BUSY is ignored: no restart, no queueing.
- ctrl_div while in DONE is accepted, with the same behaviour as in IDLE.
- reset during BUSY aborts the operation: IDLE next cycle, all outputs 0, no ready pulse.
- reset and ctrl_div on the same edge: reset wins.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- When defined, operands are two's complement:
  - The divider runs on magnitudes.
  - Quotient sign = A[31] xor B[31]; remainder sign = sign of the dividend.
  - Negation is applied when loading the output registers in DONE, adding no cycles.
  - -2^31 / -1 gives data_result=0x80000000, data_remainder=0, data_exception=1, with normal latency.
- When undefined, operation is unsigned only, with no sign logic. 0x80000000 / 0xFFFFFFFF = 0 remainder 0x80000000, exception 0.

Decomposition:
- Shared package (div_pkg):
  - WIDTH and CNT_W defaults
  - FSM state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
  - iteration count constant LAST_STEP=WIDTH-1
- One sub-module, div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Built on the team's existing adder/subtractor cell so the step is independently unit-testable.
- The FSM, counter and output registers stay in div_multicycle.

Test Plan:
- Reset, then pulse ctrl_div with A=100, B=7 → busy=1 for cycles 1..32; resultRDY=1 only in cycle 33; result=14, remainder=2, exception=0.
- A=0xFFFFFFFF, B=1 → result=0xFFFFFFFF, remainder=0 at cycle 33 (unsigned build).
- A=1234, B=0 → resultRDY in cycle 1, exception=1, result=0, remainder=1234.
- Start A=50, B=5; re-pulse ctrl_div with A=9, B=3 at cycle 10 → the second pulse is ignored; result=10, remainder=0 at cycle 33. Then pulse reset at cycle 5 of a fresh op → no ready pulse, all outputs 0.
- DIV_SIGNED_EN builds:
  - A=-7, B=2 → result=-3 (0xFFFFFFFD), remainder=-1.
  - A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1.
- Back-to-back: ctrl_div asserted in the DONE cycle of op1 (A=20, B=4) with A=21, B=4 → op1 gives 5 r0; op2 is accepted the same cycle and gives 5 r1 33 cycles later.
